// File: rtl/sock_feed_sequencer.sv
// -----------------------------------------------------------------------------
// sock_feed_sequencer
//
// Initiator side of the sock-counter interface. Takes packing orders
// (product type, size code, number of packs) from the order panel and drives
// the PH/SR/T/PLS stimulus bus shared by the per-product pack counters.
//
// Each pack is one gap-free burst of SOCKS_PER_PACK stimulus cycles. After a
// burst the sequencer waits for the CO pulse of the selected counter. It then
// leaves one idle cycle so the counter can return to 000 before the next
// burst starts. Progress is reported on packs_done and done. Faults are
// reported on the sticky err flag.
//
// Optional feature (compile-time macro SOCK_WDT_EN):
//   defined   - WAIT gives up after CO_TIMEOUT cycles without co_in. It then
//               raises err and returns to IDLE without a done pulse, and
//               packs_done keeps its value.
//   undefined - WAIT waits for co_in indefinitely; CO_TIMEOUT is only
//               range-checked.
//
// Handshake: an order transfers on a rising clk edge where ord_valid and
// ord_ready are both high. ord_ready is high only in IDLE. An order offered
// while busy is not taken and is not queued. A zero-quantity order is
// consumed but rejected: err is set and the FSM stays in IDLE.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high
//   ord_valid    in   1      order request, qualified with ord_ready
//   ord_type     in   3      product type, forwarded on T
//   ord_size     in   2      size code, forwarded on PLS
//   ord_qty      in   QTY_W  number of packs (0 = reject)
//   ord_ready    out  1      high only in IDLE
//   PH           out  1      part-present strobe to counters
//   SR           out  1      sensor-ready strobe to counters
//   T            out  3      product type to counters
//   PLS          out  2      size code to counters
//   co_in        in   1      CO from the counter matching the current order
//   busy         out  1      high in every state except IDLE
//   packs_done   out  QTY_W  packs acknowledged for the current order
//   done         out  1      one-cycle pulse when the last pack is acknowledged
//   err          out  1      sticky fault flag, cleared by the next accepted order
// -----------------------------------------------------------------------------
module sock_feed_sequencer #(
    parameter int SOCKS_PER_PACK = 3,
    parameter int QTY_W          = 4,
    parameter int CO_TIMEOUT     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ord_valid,
    input  logic [2:0]       ord_type,
    input  logic [1:0]       ord_size,
    input  logic [QTY_W-1:0] ord_qty,
    output logic             ord_ready,
    output logic             PH,
    output logic             SR,
    output logic [2:0]       T,
    output logic [1:0]       PLS,
    input  logic             co_in,
    output logic             busy,
    output logic [QTY_W-1:0] packs_done,
    output logic             done,
    output logic             err
);

    // Beat counter width: enough to hold SOCKS_PER_PACK-1.
    localparam int BEAT_W = (SOCKS_PER_PACK > 1) ? $clog2(SOCKS_PER_PACK) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SOCKS_PER_PACK - 1);
    localparam logic [QTY_W-1:0]  QTY_ONE   = QTY_W'(1);

    // Reject configurations that cannot describe a real burst or timeout.
    if (SOCKS_PER_PACK < 1 || QTY_W < 1 || CO_TIMEOUT < 1) begin : g_bad_params
        $error("sock_feed_sequencer: SOCKS_PER_PACK, QTY_W and CO_TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state;
    logic [QTY_W-1:0]  qty;       // packs requested by the order in progress
    logic [BEAT_W-1:0] beat;      // stimulus cycles already issued in this burst

`ifdef SOCK_WDT_EN
    localparam int WAIT_W = (CO_TIMEOUT > 1) ? $clog2(CO_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CO_TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt;  // WAIT cycles already spent without co_in
`endif

    // Single FSM block. Every output is a register, so the counters see a
    // glitch-free bus. All outputs go to their idle values as soon as reset
    // is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            qty        <= '0;
            beat       <= '0;
            ord_ready  <= 1'b1;
            PH         <= 1'b0;
            SR         <= 1'b0;
            T          <= 3'd0;
            PLS        <= 2'd0;
            busy       <= 1'b0;
            packs_done <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef SOCK_WDT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            // done is a pulse and is only re-asserted on the completing edge.
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ord_valid) begin
                        if (ord_qty != '0) begin
                            qty        <= ord_qty;
                            T          <= ord_type;
                            PLS        <= ord_size;
                            packs_done <= '0;
                            err        <= 1'b0;
                            beat       <= '0;
                            PH         <= 1'b1;
                            SR         <= 1'b1;
                            busy       <= 1'b1;
                            ord_ready  <= 1'b0;
                            state      <= S_FEED;
                        end else begin
                            // Empty order: consumed, flagged, nothing driven.
                            err <= 1'b1;
                        end
                    end
                end

                S_FEED: begin
                    if (beat == LAST_BEAT) begin
                        // This cycle is the last stimulus cycle of the burst.
                        PH    <= 1'b0;
                        SR    <= 1'b0;
                        state <= S_WAIT;
`ifdef SOCK_WDT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (co_in) begin
                        packs_done <= packs_done + QTY_ONE;
                        if ((packs_done + QTY_ONE) == qty) begin
                            // The last pack is acknowledged. Release the bus
                            // and return to IDLE.
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            ord_ready <= 1'b1;
                            T         <= 3'd0;
                            PLS       <= 2'd0;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_GAP;
                        end
                    end
`ifdef SOCK_WDT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        // The counter never answered. Abandon the order and
                        // keep packs_done as it is.
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        ord_ready <= 1'b1;
                        T         <= 3'd0;
                        PLS       <= 2'd0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_GAP: begin
                    // One quiet cycle lets the counter return from 111 to 000.
                    // After it, the next burst starts.
                    beat  <= '0;
                    PH    <= 1'b1;
                    SR    <= 1'b1;
                    state <= S_FEED;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A CO pulse outside WAIT is a counter fault. It is flagged and has
            // no other effect. It overrides the err clear of an order accepted
            // on the same edge, so the fault is not lost.
            if (co_in && (state != S_WAIT)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sock_feed_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sock_feed_sequencer
//
// Randomized and directed stimulus for sock_feed_sequencer.
//
// For every accepted order the reference model expects:
//   - qty bursts, each carrying {type, size} on T/PLS;
//   - a done pulse with packs_done == qty.
// These expectations go into queues. A monitor pops an entry each time it
// sees the end of a burst or a done pulse.
//
// A responder process drives co_in:
//   - automatic CO one cycle after each burst;
//   - a one-shot stray CO during a burst;
//   - a one-shot late CO.
//
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sock_feed_sequencer;

    localparam int SOCKS_PER_PACK = 3;
    localparam int QTY_W          = 4;
    localparam int CO_TIMEOUT     = 8;

    logic             clk;
    logic             reset;
    logic             ord_valid;
    logic [2:0]       ord_type;
    logic [1:0]       ord_size;
    logic [QTY_W-1:0] ord_qty;
    logic             ord_ready;
    logic             PH;
    logic             SR;
    logic [2:0]       T;
    logic [1:0]       PLS;
    logic             co_in;
    logic             busy;
    logic [QTY_W-1:0] packs_done;
    logic             done;
    logic             err;

    sock_feed_sequencer #(
        .SOCKS_PER_PACK (SOCKS_PER_PACK),
        .QTY_W          (QTY_W),
        .CO_TIMEOUT     (CO_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ord_valid  (ord_valid),
        .ord_type   (ord_type),
        .ord_size   (ord_size),
        .ord_qty    (ord_qty),
        .ord_ready  (ord_ready),
        .PH         (PH),
        .SR         (SR),
        .T          (T),
        .PLS        (PLS),
        .co_in      (co_in),
        .busy       (busy),
        .packs_done (packs_done),
        .done       (done),
        .err        (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    int ph_total = 0;

    logic [4:0]       exp_burst_q[$];   // expected {T, PLS} per pack
    logic [QTY_W-1:0] exp_done_q[$];    // expected packs_done at each done pulse

    logic co_auto;          // answer every burst with CO one cycle later
    logic stray_req;        // one CO while PH is high
    logic co_manual_req;    // one CO on the next falling edge

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        int         run;
        logic [4:0] cap;
        logic [4:0] e;
        logic [QTY_W-1:0] ed;
        run = 0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
            end else begin
                if (PH) begin
                    if (run == 0) cap = {T, PLS};
                    check("sr_with_ph", {31'd0, SR}, 32'd1);
                    run++;
                    ph_total++;
                end else if (run != 0) begin
                    if (exp_burst_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_burst: got fields %0h, expected no burst", cap);
                    end else begin
                        e = exp_burst_q.pop_front();
                        check("burst_fields", {27'd0, cap}, {27'd0, e});
                    end
                    check("burst_len", run, SOCKS_PER_PACK);
                    run = 0;
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got done=1 packs_done=%0d, expected no done", packs_done);
                    end else begin
                        ed = exp_done_q.pop_front();
                        check("done_packs", {28'd0, packs_done}, {28'd0, ed});
                    end
                end
            end
        end
    end

    // ---------------- CO responder ----------------
    initial begin
        logic prev;
        prev  = 1'b0;
        co_in = 1'b0;
        forever begin
            @(negedge clk);
            co_in = 1'b0;
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (co_auto && prev && !PH) begin
                    co_in = 1'b1;
                end else if (stray_req && PH) begin
                    co_in = 1'b1;
                    stray_req = 1'b0;
                end else if (co_manual_req) begin
                    co_in = 1'b1;
                    co_manual_req = 1'b0;
                end
                prev = PH;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (ord_ready) break;
            @(negedge clk);
        end
        check("ready_timeout", {31'd0, ord_ready}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Issue one order and let the model predict its bursts and done pulse.
    task automatic run_order(input logic [2:0] ty, input logic [1:0] sz, input logic [QTY_W-1:0] q);
        wait_ready();
        ord_valid = 1'b1;
        ord_type  = ty;
        ord_size  = sz;
        ord_qty   = q;
        for (int p = 0; p < int'(q); p++) exp_burst_q.push_back({ty, sz});
        if (q != '0) exp_done_q.push_back(q);
        @(negedge clk);
        ord_valid = 1'b0;
        if (q == '0) begin
            check("zero_qty_err", {31'd0, err}, 32'd1);
            check("zero_qty_idle", {30'd0, busy, PH}, 32'd0);
        end else begin
            check("accept_busy", {30'd0, busy, ord_ready}, 32'd2);
            check("accept_err_clr", {31'd0, err}, 32'd0);
            wait_idle();
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int ph0;
        int cnt;
        reset         = 1'b1;
        ord_valid     = 1'b0;
        ord_type      = '0;
        ord_size      = '0;
        ord_qty       = '0;
        co_auto       = 1'b1;
        stray_req     = 1'b0;
        co_manual_req = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ord_ready", {31'd0, ord_ready}, 32'd1);
        check("rst_ph_sr", {30'd0, PH, SR}, 32'd0);
        check("rst_t_pls", {27'd0, T, PLS}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_packs_done", {28'd0, packs_done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two packs of type 001, size 01.
        run_order(3'b001, 2'b01, 4'd2);
        check("t1_packs_done", {28'd0, packs_done}, 32'd2);
        check("t1_ready", {31'd0, ord_ready}, 32'd1);

        // Zero quantity is rejected; the next valid order clears err.
        run_order(3'b010, 2'b10, 4'd0);
        repeat (3) @(negedge clk);
        check("t2_still_idle", {30'd0, busy, PH}, 32'd0);
        run_order(3'b011, 2'b11, 4'd1);
        check("t2_err_cleared", {31'd0, err}, 32'd0);

        // A stray CO during a burst sets err and does not change the count.
        stray_req = 1'b1;
        run_order(3'b100, 2'b00, 4'd2);
        check("t3_stray_err", {31'd0, err}, 32'd1);
        check("t3_packs_done", {28'd0, packs_done}, 32'd2);

        // Random orders.
        for (int k = 0; k < 8; k++) begin
            logic [2:0]       rty;
            logic [1:0]       rsz;
            logic [QTY_W-1:0] rq;
            rty = 3'($urandom_range(0, 7));
            rsz = 2'($urandom_range(0, 3));
            rq  = QTY_W'($urandom_range(1, 4));
            run_order(rty, rsz, rq);
            check("rnd_packs_done", {28'd0, packs_done}, {28'd0, rq});
            check("rnd_err", {31'd0, err}, 32'd0);
        end

        // Reset on the 2nd FEED cycle of pack 1: the bus drops at once and
        // no done pulse follows.
        wait_ready();
        ord_valid = 1'b1;
        ord_type  = 3'b111;
        ord_size  = 2'b11;
        ord_qty   = 4'd2;
        @(negedge clk);
        ord_valid = 1'b0;
        @(negedge clk);
        check("t5_second_feed", {31'd0, PH}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_bus_dropped", {25'd0, PH, SR, T, PLS}, 32'd0);
        check("t5_busy_dropped", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_idle_after", {29'd0, ord_ready, busy, done}, 32'd4);

        // ord_valid held high during a qty=3 order: only one order is taken.
        wait_ready();
        ph0 = ph_total;
        ord_valid = 1'b1;
        ord_type  = 3'b101;
        ord_size  = 2'b10;
        ord_qty   = 4'd3;
        for (int p = 0; p < 3; p++) exp_burst_q.push_back({3'b101, 2'b10});
        exp_done_q.push_back(4'd3);
        @(negedge clk);
        cnt = 0;
        while (!done && cnt < 300) begin
            check("t6_not_ready", {31'd0, ord_ready}, 32'd0);
            @(negedge clk);
            cnt++;
        end
        ord_valid = 1'b0;
        check("t6_done_seen", {31'd0, done}, 32'd1);
        repeat (4) @(negedge clk);
        check("t6_no_requeue", {31'd0, busy}, 32'd0);
        check("t6_ph_cycles", ph_total - ph0, 9);

`ifdef SOCK_WDT_EN
        // No CO at all: err is raised after CO_TIMEOUT WAIT cycles, with no done pulse.
        co_auto = 1'b0;
        wait_ready();
        ord_valid = 1'b1;
        ord_type  = 3'b110;
        ord_size  = 2'b01;
        ord_qty   = 4'd1;
        exp_burst_q.push_back({3'b110, 2'b01});
        @(negedge clk);
        ord_valid = 1'b0;
        cnt = 0;
        while (PH && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("wdt_cycles", cnt, CO_TIMEOUT);
        check("wdt_err", {31'd0, err}, 32'd1);
        check("wdt_packs_frozen", {28'd0, packs_done}, 32'd0);
        co_auto = 1'b1;
`else
        // WAIT has no timeout: a CO that arrives much later still completes the pack.
        co_auto = 1'b0;
        wait_ready();
        ord_valid = 1'b1;
        ord_type  = 3'b110;
        ord_size  = 2'b01;
        ord_qty   = 4'd1;
        exp_burst_q.push_back({3'b110, 2'b01});
        exp_done_q.push_back(4'd1);
        @(negedge clk);
        ord_valid = 1'b0;
        repeat (25) @(negedge clk);
        check("late_co_still_busy", {31'd0, busy}, 32'd1);
        check("late_co_no_err", {31'd0, err}, 32'd0);
        co_manual_req = 1'b1;
        wait_idle();
        check("late_co_packs", {28'd0, packs_done}, 32'd1);
        co_auto = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_burst_q.size() + exp_done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
